// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift mode encodings shared by the pipelined shifter
package shifter_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRA = 2'b01,
      SHIFT_ROR = 2'b10,
      SHIFT_SRL = 2'b11
   } shift_mode_t;

endpackage

// File: rtl/shifter_stage.sv
// rtl/shifter_stage.sv - combinational single-distance shift for all four modes
module shifter_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  logic             en,
   input  shift_mode_t      mode,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = din;
      if (en) begin
         case (mode)
            SHIFT_SLL: dout = din << DIST;
            SHIFT_SRA: dout = {{DIST{din[WIDTH-1]}}, din[WIDTH-1:DIST]};
            SHIFT_SRL: dout = din >> DIST;
            SHIFT_ROR: dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
            default:   dout = din;
         endcase
      end
   end

endmodule

// File: rtl/shifter_pipe.sv
// rtl/shifter_pipe.sv - pipelined log barrel shifter with valid/ready and tag
// Optional result flags (out_zero/out_neg) enabled by SHIFTER_PIPE_FLAGS_EN.
module shifter_pipe
   import shifter_pkg::*;
#(
   parameter  int WIDTH   = 16,
   parameter  int TAG_W   = 4,
   localparam int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_mode,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_zero,
   output logic               out_neg
);

   localparam int S = SHAMT_W;

   // Index 0 captures the accepted operation; index k+1 holds it after stage k.
   logic                valid_q [0:S];
   logic [WIDTH-1:0]    data_q  [0:S];
   logic [TAG_W-1:0]    tag_q   [0:S];
   shift_mode_t         mode_q  [0:S-1];
   logic [SHAMT_W-1:0]  shamt_q [0:S-1];
   logic [WIDTH-1:0]    shifted [0:S-1];
   logic                advance;
   logic                unused_shamt;

   assign advance  = !valid_q[S] || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < S; k++) begin : g_stage
      shifter_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k)
      ) u_stage (
         .en   (shamt_q[k][k]),
         .mode (mode_q[k]),
         .din  (data_q[k]),
         .dout (shifted[k])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= S; k++) begin
            valid_q[k] <= 1'b0;
            data_q[k]  <= '0;
            tag_q[k]   <= '0;
         end
         for (int k = 0; k < S; k++) begin
            mode_q[k]  <= SHIFT_SLL;
            shamt_q[k] <= '0;
         end
      end else if (advance) begin
         // Data is captured even for bubbles; only the valid bit marks them.
         valid_q[0] <= in_valid;
         data_q[0]  <= in_data;
         tag_q[0]   <= in_tag;
         mode_q[0]  <= shift_mode_t'(in_mode);
         shamt_q[0] <= in_shamt;
         for (int k = 0; k < S; k++) begin
            valid_q[k+1] <= valid_q[k];
            data_q[k+1]  <= shifted[k];
            tag_q[k+1]   <= tag_q[k];
         end
         for (int k = 0; k < S-1; k++) begin
            mode_q[k+1]  <= mode_q[k];
            shamt_q[k+1] <= shamt_q[k];
         end
      end
   end

   // Each stage only consumes its own amount bit; fold the rest away.
   always_comb begin
      unused_shamt = 1'b0;
      for (int k = 0; k < S; k++) begin
         for (int b = 0; b < SHAMT_W; b++) begin
            if (b != k) unused_shamt = unused_shamt ^ shamt_q[k][b];
         end
      end
   end

   assign out_valid = valid_q[S];
   assign out_data  = data_q[S];
   assign out_tag   = tag_q[S];

`ifdef SHIFTER_PIPE_FLAGS_EN
   logic zero_q;
   logic neg_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (advance) begin
         zero_q <= (shifted[S-1] == '0);
         neg_q  <= shifted[S-1][WIDTH-1];
      end
   end

   assign out_zero = zero_q;
   assign out_neg  = neg_q;
`else
   assign out_zero = 1'b0;
   assign out_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_shifter_pipe.sv
// tb/tb_shifter_pipe.sv - randomized scoreboard bench for shifter_pipe
module tb_shifter_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [3:0]  in_shamt;
   logic [1:0]  in_mode;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_tag;
   logic        out_zero;
   logic        out_neg;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  tag;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        cur_exp;
   int          errors = 0;
   int          checks = 0;
   int          run_len = 0;
   int          max_run = 0;
   bit          rand_ready = 0;

   always #5 clk = ~clk;

   shifter_pipe #(.WIDTH(16), .TAG_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_mode   (in_mode),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_zero  (out_zero),
      .out_neg   (out_neg)
   );

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [15:0] d, input int s, input logic [1:0] m);
      logic signed [15:0] sd;
      logic [31:0]        dd;
      sd = d;
      dd = {d, d} >> s;
      case (m)
         2'b00:   return d << s;
         2'b01:   return sd >>> s;
         2'b10:   return dd[15:0];
         default: return d >> s;
      endcase
   endfunction

   // Scoreboard: every valid output must be the oldest outstanding result.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         run_len = 0;
      end else begin
         if (out_valid) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (exp_q.size() == 0) begin
               check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               check("out_data", 32'(out_data), 32'(exp_q[0].data));
               check("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
`ifdef SHIFTER_PIPE_FLAGS_EN
               check("out_zero", 32'(out_zero), 32'(exp_q[0].data == 16'h0));
               check("out_neg", 32'(out_neg), 32'(exp_q[0].data[15]));
`else
               check("out_zero_off", 32'(out_zero), 32'd0);
               check("out_neg_off", 32'(out_neg), 32'd0);
`endif
               if (out_ready) void'(exp_q.pop_front());
            end
         end else begin
            run_len = 0;
         end
         if (in_valid && in_ready) exp_q.push_back(cur_exp);
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic send(input logic [15:0] d, input logic [3:0] s, input logic [1:0] m,
                       input logic [3:0] t, input logic [15:0] e);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = s;
      in_mode  = m;
      in_tag   = t;
      cur_exp.data = e;
      cur_exp.tag  = t;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int lat;
      logic [15:0] d;
      logic [3:0]  s;
      logic [1:0]  m;
      logic [3:0]  t;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0;
      in_mode = '0; in_tag = '0; out_ready = 1'b1;
      cur_exp.data = '0; cur_exp.tag = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_out_neg", 32'(out_neg), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Latency of a lone operation
      send(16'h1234, 4'd4, 2'b00, 4'd3, 16'h2340);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check("latency", 32'(lat), 32'd4);
      check("sll_data", 32'(out_data), 32'h2340);
      check("sll_tag", 32'(out_tag), 32'd3);
      drain("drain_first");

      // Directed boundary cases
      send(16'h8000, 4'd15, 2'b01, 4'd1, 16'hFFFF);
      send(16'h8000, 4'd15, 2'b11, 4'd2, 16'h0001);
      send(16'h7FF0, 4'd4,  2'b01, 4'd3, 16'h07FF);
      send(16'h1234, 4'd4,  2'b10, 4'd4, 16'h4123);
      send(16'h8001, 4'd1,  2'b10, 4'd5, 16'hC000);
      send(16'h1234, 4'd15, 2'b10, 4'd6, 16'h2468);
      send(16'h8001, 4'd15, 2'b00, 4'd7, 16'h8000);
      for (int i = 0; i < 4; i++) send(16'hA5A5, 4'd0, 2'(i), 4'(8 + i), 16'hA5A5);
      send(16'h8000, 4'd1,  2'b00, 4'd12, 16'h0000);
      send(16'h8000, 4'd2,  2'b01, 4'd13, 16'hE000);
      drain("drain_directed");

      // Eight back-to-back ops with a free-running consumer
      max_run = 0;
      for (int i = 0; i < 8; i++) begin
         d = 16'($urandom); s = 4'($urandom); m = 2'($urandom);
         send(d, s, m, 4'(i), model(d, int'(s), m));
      end
      drain("drain_b2b");
      check("b2b_run", 32'(max_run), 32'd8);

      // Same again, then stall the consumer for five cycles
      for (int i = 0; i < 8; i++) begin
         d = 16'($urandom); s = 4'($urandom); m = 2'($urandom);
         send(d, s, m, 4'(i + 8), model(d, int'(s), m));
      end
      out_ready = 1'b0;
      repeat (5) begin
         #1;
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      drain("drain_stall");

      // Reset with three operations in flight
      for (int i = 0; i < 3; i++) send(16'hFFFF, 4'd1, 2'b00, 4'(i + 1), 16'hFFFE);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_flight_valid", 32'(out_valid), 32'd0);
      check("rst_flight_data", 32'(out_data), 32'd0);
      check("rst_flight_tag", 32'(out_tag), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", 32'(in_ready), 32'd1);
      repeat (10) begin
         @(posedge clk);
         #1;
         check("post_rst_idle", 32'(out_valid), 32'd0);
      end

      // Randomized traffic with random back-pressure
      rand_ready = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         d = 16'($urandom); s = 4'($urandom); m = 2'($urandom); t = 4'($urandom);
         send(d, s, m, t, model(d, int'(s), m));
      end
      rand_ready = 0;
      @(posedge clk);
      #2 out_ready = 1'b1;
      drain("drain_random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
